aes_vector_sequencer: RTL and testbench

Synthesizable, self-checking stimulus engine for the AES core with its side-channel output (`Capacitance`). It replaces fixed hand-driven state/key stimulus.
- Walks NUM_VEC state/key/expected triples from an external synchronous vector store and drives each into the core.
- Samples the core output a fixed CORE_LAT cycles later and compares it.
- Counts mismatches and counts toggles on the capacitance bus while running.
- Sits between a vector ROM and the core's state/key/out/Capacitance ports.

---
 rtl/aes_vector_sequencer_if.sv | 50 +++++
 rtl/aes_vector_sequencer.sv | 175 +++++++++++++++++
 tb/tb_aes_vector_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_vector_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : aes_vector_sequencer_if
// Description : Bundle of vector-store, core-facing and result signals used by
//               the AES vector sequencer. The sequencer uses the slave view;
//               the surrounding environment (vector ROM, core, host) uses the
//               master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_vector_sequencer_if #(
  parameter int DATA_W = 128,
  parameter int KEY_W  = 128,
  parameter int CAP_W  = 64,
  parameter int VEC_AW = 4,
  parameter int CNT_W  = 16
);
  // Run control
  logic              start;
  // Vector store
  logic [VEC_AW-1:0] vec_addr;
  logic [DATA_W-1:0] vec_state;
  logic [KEY_W-1:0]  vec_key;
  logic [DATA_W-1:0] vec_expect;
  // Core ports
  logic [DATA_W-1:0] dut_state;
  logic [KEY_W-1:0]  dut_key;
  logic [DATA_W-1:0] dut_out;
  logic [CAP_W-1:0]  dut_cap;
  // Results
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_count;
  logic [VEC_AW-1:0] first_err_idx;
  logic [CNT_W-1:0]  cap_toggles;

  modport master (
    output start, vec_state, vec_key, vec_expect, dut_out, dut_cap,
    input  vec_addr, dut_state, dut_key, busy, done, pass,
           err_count, first_err_idx, cap_toggles
  );

  modport slave (
    input  start, vec_state, vec_key, vec_expect, dut_out, dut_cap,
    output vec_addr, dut_state, dut_key, busy, done, pass,
           err_count, first_err_idx, cap_toggles
  );
endinterface
`default_nettype wire

// File: rtl/aes_vector_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : aes_vector_sequencer
// Description : Walks NUM_VEC state/key/expected triples from a synchronous
//               vector store, drives each into the AES core, samples the core
//               result CORE_LAT edges later and compares it. Counts mismatches
//               and capacitance-bus toggles while a run is active.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_vector_sequencer #(
  parameter int DATA_W   = 128,
  parameter int KEY_W    = 128,
  parameter int CAP_W    = 64,
  parameter int NUM_VEC  = 16,
  parameter int VEC_AW   = 4,
  parameter int CORE_LAT = 21,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_vector_sequencer_if.slave seq_if
);

  // Wait counter only ever holds values 1..CORE_LAT-1.
  localparam int WAIT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  localparam logic [VEC_AW-1:0] LAST_ADDR = VEC_AW'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(CORE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRIVE = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              start_run;
  logic              busy_d;
  logic              mismatch;

  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [VEC_AW-1:0] vec_addr_q;
  logic [DATA_W-1:0] dut_state_q;
  logic [KEY_W-1:0]  dut_key_q;
  logic [DATA_W-1:0] expect_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  err_count_q;
  logic [VEC_AW-1:0] first_err_idx_q;
  logic [CNT_W-1:0]  cap_toggles_q;
  logic [CAP_W-1:0]  cap_snap_q;

  assign mismatch = (state_q == S_CHECK) && (seq_if.dut_out != expect_q);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured when no run is in progress.
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (seq_if.start) begin
          state_d   = S_FETCH;
          start_run = 1'b1;
        end
      end
      S_FETCH: state_d = S_DRIVE;
      S_DRIVE: state_d = (CORE_LAT == 1) ? S_CHECK : S_WAIT;
      S_WAIT:  if (wait_q == WAIT_W'(1)) state_d = S_CHECK;
      S_CHECK: state_d = (vec_addr_q == LAST_ADDR) ? S_DONE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FETCH) || (state_d == S_DRIVE) ||
             (state_d == S_WAIT)  || (state_d == S_CHECK);
  end

  // Core stimulus registers and latency counter; core inputs hold between runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_state_q <= '0;
      dut_key_q   <= '0;
      expect_q    <= '0;
      wait_q      <= '0;
    end else if (state_q == S_DRIVE) begin
      dut_state_q <= seq_if.vec_state;
      dut_key_q   <= seq_if.vec_key;
      expect_q    <= seq_if.vec_expect;
      wait_q      <= WAIT_INIT;
    end else if (state_q == S_WAIT) begin
      wait_q      <= wait_q - WAIT_W'(1);
    end
  end

  // Vector address, result comparison and run status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      vec_addr_q      <= '0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (start_run) begin
        done_q          <= 1'b0;
        pass_q          <= 1'b0;
        vec_addr_q      <= '0;
        err_count_q     <= '0;
        first_err_idx_q <= '0;
      end else begin
        if (state_q == S_DONE) begin
          done_q <= 1'b1;
          pass_q <= (err_count_q == '0);
        end
        if (state_q == S_CHECK) begin
          if (mismatch) begin
            if (err_count_q != CNT_MAX) begin
              err_count_q <= err_count_q + CNT_W'(1);
            end
            // Counter never returns to zero within a run, so zero marks "no error yet".
            if (err_count_q == '0) begin
              first_err_idx_q <= vec_addr_q;
            end
          end
          if (vec_addr_q != LAST_ADDR) begin
            vec_addr_q <= vec_addr_q + VEC_AW'(1);
          end
        end
      end
    end
  end

  // Capacitance activity monitor: counts busy cycles on which the bus changed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_snap_q    <= '0;
      cap_toggles_q <= '0;
    end else begin
      cap_snap_q <= seq_if.dut_cap;
      if (start_run) begin
        cap_toggles_q <= '0;
      end else if (busy_q && (seq_if.dut_cap != cap_snap_q) &&
                   (cap_toggles_q != CNT_MAX)) begin
        cap_toggles_q <= cap_toggles_q + CNT_W'(1);
      end
    end
  end

  assign seq_if.vec_addr      = vec_addr_q;
  assign seq_if.dut_state     = dut_state_q;
  assign seq_if.dut_key       = dut_key_q;
  assign seq_if.busy          = busy_q;
  assign seq_if.done          = done_q;
  assign seq_if.pass          = pass_q;
  assign seq_if.err_count     = err_count_q;
  assign seq_if.first_err_idx = first_err_idx_q;
  assign seq_if.cap_toggles   = cap_toggles_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_vector_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_aes_vector_sequencer
// Description : Directed self-checking bench for aes_vector_sequencer. Three
//               instances: u0 (4 vectors, latency 3), u1 (same, 2-bit
//               counters) and u2 (1 vector, latency 1). Each has its own
//               vector ROM model and behavioural core (out = state ^ key).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_vector_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  aes_vector_sequencer_if #(.DATA_W(32), .KEY_W(32), .CAP_W(8), .VEC_AW(2), .CNT_W(16)) if0 ();
  aes_vector_sequencer_if #(.DATA_W(32), .KEY_W(32), .CAP_W(8), .VEC_AW(2), .CNT_W(2))  if1 ();
  aes_vector_sequencer_if #(.DATA_W(32), .KEY_W(32), .CAP_W(8), .VEC_AW(1), .CNT_W(16)) if2 ();

  aes_vector_sequencer #(.DATA_W(32), .KEY_W(32), .CAP_W(8), .NUM_VEC(4), .VEC_AW(2),
                         .CORE_LAT(3), .CNT_W(16))
    u0 (.clk(clk), .rst(rst), .seq_if(if0));
  aes_vector_sequencer #(.DATA_W(32), .KEY_W(32), .CAP_W(8), .NUM_VEC(4), .VEC_AW(2),
                         .CORE_LAT(3), .CNT_W(2))
    u1 (.clk(clk), .rst(rst), .seq_if(if1));
  aes_vector_sequencer #(.DATA_W(32), .KEY_W(32), .CAP_W(8), .NUM_VEC(1), .VEC_AW(1),
                         .CORE_LAT(1), .CNT_W(16))
    u2 (.clk(clk), .rst(rst), .seq_if(if2));

  // Vector table; expected = state ^ key computed by hand.
  logic [31:0] rom_s [0:3];
  logic [31:0] rom_k [0:3];
  logic [31:0] rom_e [0:3];
  logic [3:0]  u0_bad;
  logic        u1_bad;
  logic [31:0] c0_p1, c0_p2, c1_p1, c1_p2;

  initial begin
    rom_s[0] = 32'h1234_5678; rom_k[0] = 32'hFFFF_0000; rom_e[0] = 32'hEDCB_5678;
    rom_s[1] = 32'hA5A5_A5A5; rom_k[1] = 32'h0F0F_0F0F; rom_e[1] = 32'hAAAA_AAAA;
    rom_s[2] = 32'h0000_0001; rom_k[2] = 32'h8000_0000; rom_e[2] = 32'h8000_0001;
    rom_s[3] = 32'hDEAD_BEEF; rom_k[3] = 32'h0000_0000; rom_e[3] = 32'hDEAD_BEEF;
  end

  // Synchronous vector stores (one-cycle read latency) and latency-3 cores.
  always @(posedge clk) begin
    if0.vec_state  <= rom_s[if0.vec_addr];
    if0.vec_key    <= rom_k[if0.vec_addr];
    if0.vec_expect <= rom_e[if0.vec_addr] ^ (u0_bad[if0.vec_addr] ? 32'h0000_0100 : 32'h0);
    if1.vec_state  <= rom_s[if1.vec_addr];
    if1.vec_key    <= rom_k[if1.vec_addr];
    if1.vec_expect <= rom_e[if1.vec_addr] ^ (u1_bad ? 32'h0000_0001 : 32'h0);
    if2.vec_state  <= (if2.vec_addr == 1'b0) ? rom_s[1] : 32'h0;
    if2.vec_key    <= (if2.vec_addr == 1'b0) ? rom_k[1] : 32'h0;
    if2.vec_expect <= (if2.vec_addr == 1'b0) ? rom_e[1] : 32'h0;
    c0_p1 <= if0.dut_state ^ if0.dut_key;
    c0_p2 <= c0_p1;
    c1_p1 <= if1.dut_state ^ if1.dut_key;
    c1_p2 <= c1_p1;
  end

  assign if0.dut_out = c0_p2;
  assign if1.dut_out = c1_p2;
  assign if2.dut_out = if2.dut_state ^ if2.dut_key;

  // Starts u0 and counts edges from the accepting edge until done (bounded).
  task automatic run_u0(output int edges, output logic busy_after);
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start  = 1'b0;
    busy_after = if0.busy;
    edges = 0;
    while (if0.done !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
    if0.dut_cap = 8'h00; if1.dut_cap = 8'h00; if2.dut_cap = 8'h00;
    u0_bad = 4'b0000; u1_bad = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", if0.busy); end
    n_cmp++; if (if0.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", if0.done); end
    n_cmp++; if (if0.err_count !== 16'd0) begin n_err++; $display("FAIL reset_err: got %0h want 0", if0.err_count); end
    n_cmp++; if (if0.dut_state !== 32'h0) begin n_err++; $display("FAIL reset_state: got %0h want 0", if0.dut_state); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: got busy %0b want 0", if0.busy); end
  endtask

  task automatic test_clean_run();
    int   edges;
    logic b;
    run_u0(edges, b);
    n_cmp++; if (b !== 1'b1) begin n_err++; $display("FAIL clean_busy_rise: got %0b want 1", b); end
    n_cmp++; if (edges !== 21) begin n_err++; $display("FAIL clean_done_edges: got %0d want 21", edges); end
    n_cmp++; if (if0.pass !== 1'b1) begin n_err++; $display("FAIL clean_pass: got %0b want 1", if0.pass); end
    n_cmp++; if (if0.err_count !== 16'd0) begin n_err++; $display("FAIL clean_err: got %0h want 0", if0.err_count); end
    n_cmp++; if (if0.cap_toggles !== 16'd0) begin n_err++; $display("FAIL clean_cap: got %0h want 0", if0.cap_toggles); end
    n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL clean_busy_end: got %0b want 0", if0.busy); end
    n_cmp++; if (if0.vec_addr !== 2'd3) begin n_err++; $display("FAIL clean_addr_hold: got %0d want 3", if0.vec_addr); end
    n_cmp++; if (if0.dut_state !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL clean_state_hold: got %0h want deadbeef", if0.dut_state); end
    n_cmp++; if (if0.dut_key !== 32'h0) begin n_err++; $display("FAIL clean_key_hold: got %0h want 0", if0.dut_key); end
  endtask

  task automatic test_mismatch();
    int   edges;
    logic b;
    u0_bad = 4'b1100;
    run_u0(edges, b);
    n_cmp++; if (edges !== 21) begin n_err++; $display("FAIL mism_done_edges: got %0d want 21", edges); end
    n_cmp++; if (if0.err_count !== 16'd2) begin n_err++; $display("FAIL mism_err: got %0d want 2", if0.err_count); end
    n_cmp++; if (if0.first_err_idx !== 2'd2) begin n_err++; $display("FAIL mism_first: got %0d want 2", if0.first_err_idx); end
    n_cmp++; if (if0.pass !== 1'b0) begin n_err++; $display("FAIL mism_pass: got %0b want 0", if0.pass); end
  endtask

  task automatic test_reset_mid_run();
    u0_bad = 4'b0001;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_cmp++; if (if0.err_count !== 16'd1) begin n_err++; $display("FAIL midrst_pre_err: got %0d want 1", if0.err_count); end
    n_cmp++; if (if0.vec_addr !== 2'd1) begin n_err++; $display("FAIL midrst_pre_addr: got %0d want 1", if0.vec_addr); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %0b want 0", if0.busy); end
    n_cmp++; if (if0.err_count !== 16'd0) begin n_err++; $display("FAIL midrst_err: got %0d want 0", if0.err_count); end
    n_cmp++; if (if0.vec_addr !== 2'd0) begin n_err++; $display("FAIL midrst_addr: got %0d want 0", if0.vec_addr); end
    n_cmp++; if (if0.dut_state !== 32'h0) begin n_err++; $display("FAIL midrst_state: got %0h want 0", if0.dut_state); end
    @(posedge clk); #1;
    rst = 1'b0;
    u0_bad = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({if0.busy, if0.done} !== 2'b00) begin n_err++; $display("FAIL midrst_idle: got busy/done %b want 00", {if0.busy, if0.done}); end
  endtask

  task automatic test_capacitance();
    int edges;
    if0.dut_cap = 8'h11;
    @(posedge clk); #1;
    if0.dut_cap = 8'h22;
    @(posedge clk); #1;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    edges = 0;
    while (if0.done !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 2 || edges == 5 || edges == 8 || edges == 11 || edges == 14)
        if0.dut_cap = if0.dut_cap + 8'h01;
    end
    if0.dut_cap = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (edges !== 21) begin n_err++; $display("FAIL cap_done_edges: got %0d want 21", edges); end
    n_cmp++; if (if0.cap_toggles !== 16'd5) begin n_err++; $display("FAIL cap_toggles: got %0d want 5", if0.cap_toggles); end
    n_cmp++; if (if0.pass !== 1'b1) begin n_err++; $display("FAIL cap_pass: got %0b want 1", if0.pass); end
  endtask

  task automatic test_saturation_restart();
    int edges;
    u1_bad = 1'b1;
    if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    edges = 0;
    while (if1.done !== 1'b1 && edges < 200) begin @(posedge clk); #1; edges++; end
    n_cmp++; if (if1.err_count !== 2'd3) begin n_err++; $display("FAIL sat_err: got %0d want 3", if1.err_count); end
    n_cmp++; if (if1.pass !== 1'b0) begin n_err++; $display("FAIL sat_pass: got %0b want 0", if1.pass); end
    u1_bad = 1'b0;
    if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    n_cmp++; if (if1.err_count !== 2'd0) begin n_err++; $display("FAIL restart_clear_err: got %0d want 0", if1.err_count); end
    n_cmp++; if (if1.done !== 1'b0) begin n_err++; $display("FAIL restart_clear_done: got %0b want 0", if1.done); end
    edges = 0;
    while (if1.done !== 1'b1 && edges < 200) begin @(posedge clk); #1; edges++; end
    n_cmp++; if (edges !== 21) begin n_err++; $display("FAIL restart_done_edges: got %0d want 21", edges); end
    n_cmp++; if (if1.pass !== 1'b1) begin n_err++; $display("FAIL restart_pass: got %0b want 1", if1.pass); end
  endtask

  task automatic test_edge_config();
    int edges;
    if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    edges = 0;
    while (if2.done !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) if2.start = 1'b1;
      if (edges == 2) if2.start = 1'b0;
    end
    n_cmp++; if (edges !== 4) begin n_err++; $display("FAIL edge_done_edges: got %0d want 4", edges); end
    n_cmp++; if (if2.pass !== 1'b1) begin n_err++; $display("FAIL edge_pass: got %0b want 1", if2.pass); end
    n_cmp++; if (if2.dut_state !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL edge_state: got %0h want a5a5a5a5", if2.dut_state); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({if2.busy, if2.done} !== 2'b01) begin n_err++; $display("FAIL edge_hold_done: got busy/done %b want 01", {if2.busy, if2.done}); end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_mismatch();
    test_reset_mid_run();
    test_capacitance();
    test_saturation_restart();
    test_edge_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
